// File: rtl/nios_ii_system_sysid_checker.sv
// Reads the sysid slave (ID at word 0, timestamp at word 1) over Avalon-MM and
// compares both words against the expected build values, with a per-read stall timeout.
module nios_ii_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1429999420,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RD_ID  = 2'd1,
        S_RD_TS  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    // Counter value seen on the final allowed stall cycle of a read.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 16'd0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= 32'd0;
            ts_value_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RD_ID;
                    id_ok_d    = 1'b0;
                    ts_ok_d    = 1'b0;
                    timeout_d  = 1'b0;
                    wait_cnt_d = 16'd0;
                end
            end
            S_RD_ID: begin
                if (!avm_waitrequest) begin
                    id_value_d = avm_readdata;
                    id_ok_d    = (avm_readdata == EXPECTED_ID);
                    wait_cnt_d = 16'd0;
                    state_d    = S_RD_TS;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        timeout_d = 1'b1;
                        id_ok_d   = 1'b0;
                        state_d   = S_FINISH;
                    end
                end
            end
            S_RD_TS: begin
                if (!avm_waitrequest) begin
                    ts_value_d = avm_readdata;
                    ts_ok_d    = (avm_readdata == EXPECTED_TIMESTAMP);
                    wait_cnt_d = 16'd0;
                    state_d    = S_FINISH;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        timeout_d = 1'b1;
                        ts_ok_d   = 1'b0;
                        state_d   = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus strobes come straight from the state so they stay stable across stalls.
    assign avm_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    assign avm_address = (state_q == S_RD_TS);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FINISH);
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_nios_ii_system_sysid_checker.sv
// Directed bench for the sysid checker: a stall-programmable sysid slave model,
// cycle-exact bus checks, and a done-triggered scoreboard of expected results.
module tb_nios_ii_system_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1429999420;
    localparam logic [15:0] STUCK  = 16'hFFFF;
    localparam int W = 67;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic [1:0]  state_dbg;

    logic [31:0] id_data, ts_data;
    logic [15:0] id_stalls, ts_stalls;
    logic [15:0] stall_seen = 16'd0;

    int n_pass = 0;
    int n_total = 0;
    int done_cnt = 0;
    int d0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;

    always #5 clock = ~clock;

    nios_ii_system_sysid_checker #(
        .EXPECTED_ID       (EXP_ID),
        .EXPECTED_TIMESTAMP(EXP_TS),
        .TIMEOUT_CYCLES    (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .busy           (busy),
        .done           (done),
        .id_ok          (id_ok),
        .ts_ok          (ts_ok),
        .timeout        (timeout),
        .id_value       (id_value),
        .ts_value       (ts_value),
        .state_dbg      (state_dbg)
    );

    // Combinational slave: stalls each read for a programmable number of cycles.
    assign avm_readdata    = avm_address ? ts_data : id_data;
    assign avm_waitrequest = avm_read && (stall_seen < (avm_address ? ts_stalls : id_stalls));

    always @(posedge clock) begin
        if (!avm_read || !avm_waitrequest) stall_seen <= 16'd0;
        else                               stall_seen <= stall_seen + 16'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void push_exp(input logic [31:0] idv, input logic [31:0] tsv,
                                     input logic iok, input logic tok, input logic to);
        exp_q.push_back({idv, tsv, iok, tok, to});
    endfunction

    // Monitor: every done pulse pops one expected result.
    always @(negedge clock) begin
        if (!reset && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected_done: got done=1 expected no done");
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_id_value", id_value, mon_e[66:35]);
                check("sb_ts_value", ts_value, mon_e[34:3]);
                check("sb_id_ok", {31'd0, id_ok}, {31'd0, mon_e[2]});
                check("sb_ts_ok", {31'd0, ts_ok}, {31'd0, mon_e[1]});
                check("sb_timeout", {31'd0, timeout}, {31'd0, mon_e[0]});
            end
        end
    end

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic bus(input string tag, input logic rd, input logic addr,
                       input logic bsy, input logic dn);
        check({tag, "_read"}, {31'd0, avm_read}, {31'd0, rd});
        check({tag, "_addr"}, {31'd0, avm_address}, {31'd0, addr});
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, bsy});
        check({tag, "_done"}, {31'd0, done}, {31'd0, dn});
    endtask

    task automatic all_zero(input string tag);
        bus(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, "_id_ok"}, {31'd0, id_ok}, 32'd0);
        check({tag, "_ts_ok"}, {31'd0, ts_ok}, 32'd0);
        check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
        check({tag, "_id_value"}, id_value, 32'd0);
        check({tag, "_ts_value"}, ts_value, 32'd0);
        check({tag, "_state"}, {30'd0, state_dbg}, 32'd0);
    endtask

    // Returns at the first negedge after start was sampled (state RD_ID).
    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (done) seen = 1'b1;
            else cyc();
        end
        n_total++;
        if (seen) n_pass++;
        else $display("FAIL %s_done_timeout: got no done expected done within %0d cycles", tag, budget);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0;
        id_data = EXP_ID; ts_data = EXP_TS;
        id_stalls = 16'd0; ts_stalls = 16'd0;
        start = 1'b1;
        repeat (3) cyc();
        all_zero("reset");
        start = 1'b0;
        reset = 1'b0;

        // Nominal read, started in the first cycle after reset release.
        push_exp(EXP_ID, EXP_TS, 1'b1, 1'b1, 1'b0);
        pulse_start();
        bus("nom_c1", 1'b1, 1'b0, 1'b1, 1'b0); cyc();
        bus("nom_c2", 1'b1, 1'b1, 1'b1, 1'b0); cyc();
        bus("nom_c3", 1'b0, 1'b0, 1'b1, 1'b1); cyc();
        bus("nom_c4", 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        check("nom_hold_id_ok", {31'd0, id_ok}, 32'd1);

        // Timestamp mismatch.
        ts_data = 32'h12345678;
        push_exp(EXP_ID, 32'h12345678, 1'b1, 1'b0, 1'b0);
        pulse_start();
        wait_done("ts_mismatch", 10);
        ts_data = EXP_TS;

        // Three stalls on each read: one short of the timeout.
        id_stalls = 16'd3; ts_stalls = 16'd3;
        push_exp(EXP_ID, EXP_TS, 1'b1, 1'b1, 1'b0);
        pulse_start();
        for (int i = 0; i < 4; i++) begin bus("stall_id", 1'b1, 1'b0, 1'b1, 1'b0); cyc(); end
        for (int i = 0; i < 4; i++) begin bus("stall_ts", 1'b1, 1'b1, 1'b1, 1'b0); cyc(); end
        bus("stall_fin", 1'b0, 1'b0, 1'b1, 1'b1); cyc();
        id_stalls = 16'd0; ts_stalls = 16'd0;

        // ID mismatch.
        id_data = 32'd5;
        push_exp(32'd5, EXP_TS, 1'b0, 1'b1, 1'b0);
        pulse_start();
        wait_done("id_mismatch", 10);

        // ID read stuck: previous values must survive.
        id_data = 32'hAAAA0000; id_stalls = STUCK;
        push_exp(32'd5, EXP_TS, 1'b0, 1'b0, 1'b1);
        pulse_start();
        for (int i = 0; i < 4; i++) begin bus("to_id", 1'b1, 1'b0, 1'b1, 1'b0); cyc(); end
        bus("to_fin", 1'b0, 1'b0, 1'b1, 1'b1); cyc();
        cyc();
        check("to_hold_timeout", {31'd0, timeout}, 32'd1);
        id_stalls = 16'd0; id_data = EXP_ID;

        // Timestamp read stuck after a good ID.
        ts_data = 32'h0000BBBB; ts_stalls = STUCK;
        push_exp(EXP_ID, EXP_TS, 1'b1, 1'b0, 1'b1);
        pulse_start();
        wait_done("to_ts", 12);
        ts_stalls = 16'd0; ts_data = EXP_TS;

        // Start pulse during RD_TS is dropped.
        push_exp(EXP_ID, EXP_TS, 1'b1, 1'b1, 1'b0);
        d0 = done_cnt;
        pulse_start();
        check("start_clears_timeout", {31'd0, timeout}, 32'd0);
        check("start_clears_id_ok", {31'd0, id_ok}, 32'd0);
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        bus("busy_fin", 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (6) cyc();
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("busy_one_done", done_cnt - d0, 32'd1);

        // Reset in the middle of a stalled ID read.
        id_stalls = STUCK;
        pulse_start();
        bus("mid_rd", 1'b1, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        cyc();
        all_zero("mid_reset");
        reset = 1'b0;
        id_stalls = 16'd0;
        d0 = done_cnt;
        repeat (4) cyc();
        check("mid_no_done", done_cnt - d0, 32'd0);
        push_exp(EXP_ID, EXP_TS, 1'b1, 1'b1, 1'b0);
        pulse_start();
        wait_done("mid_after", 10);

        // Start held high: back-to-back sequences with one IDLE gap.
        push_exp(EXP_ID, EXP_TS, 1'b1, 1'b1, 1'b0);
        push_exp(EXP_ID, EXP_TS, 1'b1, 1'b1, 1'b0);
        start = 1'b1;
        cyc();
        bus("held_c1", 1'b1, 1'b0, 1'b1, 1'b0); cyc();
        cyc();
        bus("held_c3", 1'b0, 1'b0, 1'b1, 1'b1); cyc();
        bus("held_c4", 1'b0, 1'b0, 1'b0, 1'b0); cyc();
        bus("held_c5", 1'b1, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        wait_done("held", 10);

        repeat (3) cyc();
        check("sb_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
